// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with frame-aligned word commit, blanking guard and leading-zero suppression.
// Latency: outputs registered, one cycle behind timer/index/shown; no backpressure, load is always accepted.
module seg7_scan_driver #(
  parameter int SCAN_PERIOD  = 120000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  digit_anode,
  output logic [6:0]  segments,
  output logic        pending,
  output logic        frame
);

  localparam int TW = $clog2(SCAN_PERIOD);
  localparam logic [TW-1:0] LAST  = TW'(SCAN_PERIOD - 1);
  localparam logic [TW-1:0] BLANK = TW'(BLANK_CYCLES);

  logic [TW-1:0] timer;
  logic [1:0]    index;
  logic [15:0]   shown;
  logic [15:0]   pend_word;
  logic          pend_valid;

  logic          wrap;
  logic          commit;
  logic          in_blank;
  logic [3:0]    nib;
  logic          lead_zero;
  logic [6:0]    hex_seg;
  logic [6:0]    seg_nxt;
  logic [3:0]    anode_nxt;

  assign wrap     = (timer == LAST);
  assign commit   = wrap && (index == 2'd3);
  assign in_blank = (timer < BLANK);
  assign pending  = pend_valid;

  // lead_zero: this digit and every digit to its left are zero
  always_comb begin
    nib       = 4'h0;
    lead_zero = 1'b0;
    case (index)
      2'd0: begin nib = shown[15:12]; lead_zero = (shown[15:12] == 4'h0); end
      2'd1: begin nib = shown[11:8];  lead_zero = (shown[15:8]  == 8'h00); end
      2'd2: begin nib = shown[7:4];   lead_zero = (shown[15:4]  == 12'h000); end
      default: begin nib = shown[3:0]; lead_zero = 1'b0; end
    endcase
  end

  always_comb begin
    hex_seg = 7'b0000000;
    case (nib)
      4'h0: hex_seg = 7'b1111110;
      4'h1: hex_seg = 7'b0110000;
      4'h2: hex_seg = 7'b1101101;
      4'h3: hex_seg = 7'b1111001;
      4'h4: hex_seg = 7'b0110011;
      4'h5: hex_seg = 7'b1011011;
      4'h6: hex_seg = 7'b1011111;
      4'h7: hex_seg = 7'b1110000;
      4'h8: hex_seg = 7'b1111111;
      4'h9: hex_seg = 7'b1111011;
      4'hA: hex_seg = 7'b1110111;
      4'hB: hex_seg = 7'b0011111;
      4'hC: hex_seg = 7'b1001110;
      4'hD: hex_seg = 7'b0111101;
      4'hE: hex_seg = 7'b1001111;
      default: hex_seg = 7'b1000111;
    endcase
  end

  always_comb begin
    anode_nxt = 4'b1111;
    seg_nxt   = 7'b0000000;
    if (!in_blank) begin
      anode_nxt = ~(4'b1000 >> index);
      seg_nxt   = (blank_lz && lead_zero) ? 7'b0000000 : hex_seg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer       <= '0;
      index       <= 2'd0;
      shown       <= 16'h0000;
      pend_word   <= 16'h0000;
      pend_valid  <= 1'b0;
      digit_anode <= 4'b1111;
      segments    <= 7'b0000000;
      frame       <= 1'b0;
    end else begin
      timer <= wrap ? '0 : timer + TW'(1);
      if (wrap) index <= index + 2'd1;
      if (commit && pend_valid) shown <= pend_word;
      // a load on the commit edge stays pending for the following frame
      if (load) begin
        pend_word  <= value;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      frame       <= commit;
      digit_anode <= anode_nxt;
      segments    <= seg_nxt;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Four-digit multiplexed seven-segment scanner sitting directly downstream of the application's 16-bit display word (result / cycle-counter selection). It latches a new word on a load strobe, commits it to the display only at a frame boundary so no frame shows a mix of old and new digits, and performs hex decode. It also inserts a per-digit blanking guard against ghosting, applies optional leading-zero suppression, and drives active-low anodes plus segment lines.

## Interface
- SCAN_PERIOD, 120000: clock cycles each digit is selected (5 ms at 24 MHz); must exceed BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each digit slot with all anodes off; 0 disables the guard.
- clk  in  1  system clock (24 MHz).
- reset  in  1  asynchronous, active-low reset.
- value  in  16  display word; [15:12] leftmost digit, [3:0] rightmost.
- load  in  1  capture `value` into the pending register this cycle.
- blank_lz  in  1  1 = suppress leading zeros (rightmost digit never suppressed).
- digit_anode  out  4  active-low anode enables; [3] leftmost, [0] rightmost.
- segments  out  7  {A,B,C,D,E,F,G}, 1 = segment lit.
- pending  out  1  1 while a loaded word awaits commit.
- frame  out  1  one-cycle pulse after each frame commit point.

## Operation
- State:
  - `timer` (0..SCAN_PERIOD-1, width $clog2(SCAN_PERIOD)).
  - `index` (0..3; 0 = leftmost digit, anode[3]).
  - `shown` (16 bits).
  - `pend_word` (16 bits).
  - `pend_valid`.
- Timer: increments each cycle. At SCAN_PERIOD-1 it returns to 0 and `index` advances mod 4.
- Commit point: the edge where `index` wraps 3->0.
  - If `pend_valid` was 1 before that edge: `shown` <= `pend_word` and `pend_valid` <= 0.
  - `frame` is registered high for the following cycle regardless.
- Load: on an edge with load=1, `pend_word` <= value and `pend_valid` <= 1. A repeated load overwrites; only the last word before a commit is shown.
- Load coinciding with the commit edge:
  - Commit uses the old `pend_word`.
  - The new value becomes pending (`pend_valid` stays 1) and appears at the next frame.
- Slot phases:
  - timer < BLANK_CYCLES: blank phase. Anodes 4'b1111, segments 0.
  - Otherwise: on phase. Anode for `index` driven low, segments = decode of `shown` nibble for `index`.
- Hex decode: standard 0-F patterns. 0 = 1111110, 1 = 0110000, 8 = 1111111, A = 1110111, b = 0011111, F = 1000111.
- Leading-zero blanking (blank_lz=1):
  - A digit with index<3 is blanked (segments 0, anode still driven) when it and all digits to its left in `shown` are zero.
  - `blank_lz` is sampled live each cycle.
- No other state; no handshake back-pressure (load always accepted).

## Timing
- Reset (async assert, all state cleared immediately):
  - timer 0, index 0, shown 0, pend_word 0, pend_valid 0.
  - digit_anode 4'b1111, segments 0, pending 0, frame 0.
- Release: synchronous to clk. The first edge after release increments timer from 0.
- Outputs are registered: digit_anode/segments at cycle n+1 reflect timer, index and shown at cycle n. Result: one-cycle lag.
- Latency figures:
  - `pending` rises the cycle after load.
  - `shown` changes at the first commit edge after that. Worst case 4*SCAN_PERIOD cycles from load.
  - New segments appear one cycle after the first on-phase cycle of index 0.
- Frame length: 4*SCAN_PERIOD cycles; `frame` pulses once per frame, width 1.
- Reset mid-frame: pending word discarded; display returns to blank, then 0 (or only rightmost "0" with blank_lz).

## Test plan
(SCAN_PERIOD=8, BLANK_CYCLES=2)
- Reset, no load:
  - Anodes 1111 for the first cycle after release, then 1111 for 2 blank cycles per slot.
  - Active anode pattern 0111,1011,1101,1110 for 6 cycles each; segments 1111110 in every on phase; frame pulse every 32 cycles.
- Load 16'h12AF mid-frame (index 1):
  - `pending` goes 1 next cycle and stays until the commit edge, then drops.
  - In the next frame the digits show 0110000, 1101101, 1110111, 1000111.
- Two loads (16'h1111, then 16'h2222) within one frame: only 2222 is displayed; 1111 never appears on segments.
- Load 16'h3333 on the exact commit edge while 16'h0005 is pending:
  - Frame N+1 shows 0005.
  - Frame N+2 shows 3333; `pending` stays high across the edge.
- blank_lz=1, shown=16'h0040: digits 3 and 2 have segments 0; digit 1 shows 4 (0110011) and digit 0 shows 0. Shown=16'h0000: only the rightmost digit is lit.
- Assert reset asynchronously mid on-phase with a word pending:
  - Anodes go 1111 and segments 0 without a clock edge; `pending`=0.
  - After release, `shown`=0 is displayed.
